ctrl_main_fsm: RTL and testbench
================================

// Module: ctrl_main_fsm
// PURPOSE
//  Top-level command controller, directly upstream of the per-command sub-FSMs (get_fsm, put_fsm, del_fsm).
//  Accepts one cache request at a time over a valid/ready handshake and dispatches it to the matching sub-FSM.
//  Dispatch = 1-cycle enter pulse, then en held high until that sub-FSM reports sub_cmd_t.done (or a timeout).
//  Returns a status over a valid/ready response handshake.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles spent in RUN without done before TIMEOUT status; legal range >=1
//  CNT_W  $clog2(TIMEOUT_CYCLES+1)  timeout counter width; derived, not to be overridden
// PORTS
//  clk          in   1      single clock, posedge
//  rst_n        in   1      asynchronous, active-low reset
//  req_valid    in   1      request present
//  req_ready    out  1      controller can accept; = (state==MAIN_ST_IDLE)
//  req_op       in   2      op_e: OP_NOP=0, OP_GET=1, OP_PUT=2, OP_DEL=3
//  resp_valid   out  1      response present
//  resp_ready   in   1      consumer accepts response
//  resp_status  out  2      status_e: ST_OK=0, ST_MISS=1, ST_TIMEOUT=2, ST_ERR=3
//  hit          in   1      lookup hit from memory array; sampled only on GET done
//  get_enter    out  1      restart get_fsm (1-cycle pulse)
//  get_en       out  1      advance get_fsm
//  get_cmd      in   sub_cmd_t  get_fsm command/done struct
//  put_enter, put_en, put_cmd  same as get_* for put_fsm
//  del_enter, del_en, del_cmd  same as get_* for del_fsm
//  busy         out  1      state != MAIN_ST_IDLE
// BEHAVIOUR
//  State register
//   - Async reset: state=IDLE, op_q=OP_NOP, status_q=ST_OK, cnt=0.
//   - Hence after reset: req_ready=1; all *_enter, *_en, resp_valid, busy = 0.
//  IDLE
//   - req_ready=1.
//   - On req_valid: latch op_q=req_op.
//   - OP_NOP -> status_q=ST_ERR, go RESP. Otherwise go DISPATCH.
//  DISPATCH (1 cycle)
//   - Assert <op>_enter only; <op>_en=0.
//   - cnt=0. Go RUN.
//  RUN
//   - Assert <op>_en. Only the selected sub-FSM's cmd is observed; done from the others is ignored.
//   - If <op>_cmd.done: status_q = ST_OK for PUT/DEL; for GET, hit ? ST_OK : ST_MISS. Go RESP.
//   - Else if cnt==TIMEOUT_CYCLES-1: status_q=ST_TIMEOUT, go RESP.
//   - Else cnt++.
//   - done and timeout in the same cycle -> done wins.
//  RESP
//   - resp_valid=1, resp_status=status_q.
//   - Both held stable until resp_ready; on resp_valid&&resp_ready go IDLE.
//   - The next request can be accepted the following cycle (no same-cycle turnaround).
//  Outputs
//   - All control outputs are a decode of registered state/op_q.
//   - No combinational path from req_* or resp_ready to any output except through state.
//  Latency
//   - Accept @T, enter @T+1, en from @T+2.
//   - Done seen @T+2 earliest -> resp_valid @T+3.
//   - NOP: resp_valid @T+1.
//  Hold rules
//   - req_op is ignored outside IDLE.
//   - Exactly one *_enter/*_en pair is ever active.
//  Reset mid-operation
//   - Immediate return to IDLE; enter/en drop asynchronously.
//   - Any pending response is discarded.
//  Counter
//   - Saturation impossible: cnt<=TIMEOUT_CYCLES-1 fits CNT_W.
//   - TIMEOUT_CYCLES=1 -> RUN lasts exactly one cycle.
// STRUCTURE
//  - ctrl_types_pkg gains op_e, status_e, main_state_e {MAIN_ST_IDLE, MAIN_ST_DISPATCH, MAIN_ST_RUN, MAIN_ST_RESP}.
//    sub_cmd_t (with .done) stays in that package.
//  - One sub-module: ctrl_timeout_cnt (clear, inc, expired=cnt==LIMIT-1; param LIMIT).
//  - Dispatch decode stays inline.
// TESTING
//  - Reset: rst_n=0 -> req_ready=1, resp_valid=0, all enter/en=0, busy=0.
//  - GET hit: req_op=1, stub get_cmd.done=1 in its first en cycle, hit=1
//    -> get_enter pulse @T+1, resp_valid @T+3, status=ST_OK.
//    Repeat with hit=0 -> ST_MISS.
//  - PUT done after 5 en cycles, resp_ready low 3 cycles
//    -> put_en high exactly 5 cycles, resp_status stable ST_OK until handshake, req_ready=0 throughout.
//  - Timeout: TIMEOUT_CYCLES=4, DEL never done
//    -> del_en high 4 cycles then ST_TIMEOUT.
//    Also: done on 4th cycle -> ST_OK.
//  - NOP and cross-talk: req_op=0 -> ST_ERR @T+1, no enter.
//    During GET, assert put_cmd.done -> ignored.
//  - Reset during RUN -> IDLE next edge; next GET completes normally.

Source files
------------

// File: rtl/ctrl_types_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_types_pkg
// Shared types for the command controller and its per-command sub-FSMs.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ctrl_types_pkg;

  // Request opcode carried on req_op.
  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_GET = 2'd1,
    OP_PUT = 2'd2,
    OP_DEL = 2'd3
  } op_e;

  // Response status returned on resp_status.
  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_MISS    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ERR     = 2'd3
  } status_e;

  // Main controller states.
  typedef enum logic [1:0] {
    MAIN_ST_IDLE     = 2'd0,
    MAIN_ST_DISPATCH = 2'd1,
    MAIN_ST_RUN      = 2'd2,
    MAIN_ST_RESP     = 2'd3
  } main_state_e;

  // Sub-FSM to controller report; the controller only consumes done.
  typedef struct packed {
    logic done;
  } sub_cmd_t;

endpackage : ctrl_types_pkg

`default_nettype wire

// File: rtl/ctrl_timeout_cnt.sv
// ---------------------------------------------------------------------------
// ctrl_timeout_cnt
// Cycle counter for the RUN phase; flags the last allowed cycle.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ctrl_timeout_cnt #(
  parameter  int LIMIT = 255,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Count RUN cycles; the controller stops incrementing at c_LAST, so no wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + c_ONE;
    end
  end

  assign o_expired = (r_cnt == c_LAST);

endmodule : ctrl_timeout_cnt

`default_nettype wire

// File: rtl/ctrl_main_fsm.sv
// ---------------------------------------------------------------------------
// ctrl_main_fsm
// Top-level command controller: accepts one request, dispatches it to the
// matching sub-FSM (enter pulse, then en until done or timeout) and returns
// a status over a valid/ready response handshake.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ctrl_main_fsm
  import ctrl_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [1:0] i_req_op,
  output logic       o_resp_valid,
  input  logic       i_resp_ready,
  output logic [1:0] o_resp_status,
  input  logic       i_hit,
  output logic       o_get_enter,
  output logic       o_get_en,
  input  sub_cmd_t   i_get_cmd,
  output logic       o_put_enter,
  output logic       o_put_en,
  input  sub_cmd_t   i_put_cmd,
  output logic       o_del_enter,
  output logic       o_del_en,
  input  sub_cmd_t   i_del_cmd,
  output logic       o_busy
);

  main_state_e r_state, w_state_nxt;
  op_e         r_op,    w_op_nxt;
  status_e     r_status, w_status_nxt;
  logic        w_cnt_clear, w_cnt_inc, w_expired, w_sel_done;

  ctrl_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_cnt_clear),
    .i_inc     (w_cnt_inc),
    .o_expired (w_expired)
  );

  // State, latched opcode and pending status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MAIN_ST_IDLE;
      r_op     <= OP_NOP;
      r_status <= ST_OK;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_status <= w_status_nxt;
    end
  end

  // Next-state logic; only the selected sub-FSM's done is ever observed.
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_status_nxt = r_status;
    w_cnt_clear  = 1'b0;
    w_cnt_inc    = 1'b0;
    w_sel_done   = 1'b0;
    case (r_op)
      OP_GET:  w_sel_done = i_get_cmd.done;
      OP_PUT:  w_sel_done = i_put_cmd.done;
      OP_DEL:  w_sel_done = i_del_cmd.done;
      default: w_sel_done = 1'b0;
    endcase
    case (r_state)
      MAIN_ST_IDLE: begin
        if (i_req_valid) begin
          w_op_nxt = op_e'(i_req_op);
          if (op_e'(i_req_op) == OP_NOP) begin
            w_status_nxt = ST_ERR;
            w_state_nxt  = MAIN_ST_RESP;
          end else begin
            w_state_nxt  = MAIN_ST_DISPATCH;
          end
        end
      end
      MAIN_ST_DISPATCH: begin
        w_cnt_clear = 1'b1;
        w_state_nxt = MAIN_ST_RUN;
      end
      MAIN_ST_RUN: begin
        // done takes priority over a timeout landing in the same cycle
        if (w_sel_done) begin
          w_status_nxt = (r_op == OP_GET && !i_hit) ? ST_MISS : ST_OK;
          w_state_nxt  = MAIN_ST_RESP;
        end else if (w_expired) begin
          w_status_nxt = ST_TIMEOUT;
          w_state_nxt  = MAIN_ST_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      MAIN_ST_RESP: begin
        if (i_resp_ready) begin
          w_state_nxt = MAIN_ST_IDLE;
        end
      end
      default: w_state_nxt = MAIN_ST_IDLE;
    endcase
  end

  // Outputs are a pure decode of registered state and opcode.
  assign o_req_ready   = (r_state == MAIN_ST_IDLE);
  assign o_busy        = (r_state != MAIN_ST_IDLE);
  assign o_resp_valid  = (r_state == MAIN_ST_RESP);
  assign o_resp_status = r_status;
  assign o_get_enter   = (r_state == MAIN_ST_DISPATCH) && (r_op == OP_GET);
  assign o_put_enter   = (r_state == MAIN_ST_DISPATCH) && (r_op == OP_PUT);
  assign o_del_enter   = (r_state == MAIN_ST_DISPATCH) && (r_op == OP_DEL);
  assign o_get_en      = (r_state == MAIN_ST_RUN) && (r_op == OP_GET);
  assign o_put_en      = (r_state == MAIN_ST_RUN) && (r_op == OP_PUT);
  assign o_del_en      = (r_state == MAIN_ST_RUN) && (r_op == OP_DEL);

endmodule : ctrl_main_fsm

`default_nettype wire

// File: tb/tb_ctrl_main_fsm.sv
// ---------------------------------------------------------------------------
// tb_ctrl_main_fsm
// Directed self-checking bench for ctrl_main_fsm (default and short timeout).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ctrl_main_fsm;
  import ctrl_types_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default-timeout instance
  logic       req_valid, req_ready, resp_valid, resp_ready, hit, busy;
  logic [1:0] req_op, resp_status;
  logic       get_enter, get_en, put_enter, put_en, del_enter, del_en;
  sub_cmd_t   get_cmd, put_cmd, del_cmd;

  // TIMEOUT_CYCLES=4 instance
  logic       t_req_valid, t_req_ready, t_resp_valid, t_resp_ready, t_hit, t_busy;
  logic [1:0] t_req_op, t_resp_status;
  logic       t_get_enter, t_get_en, t_put_enter, t_put_en, t_del_enter, t_del_en;
  sub_cmd_t   t_get_cmd, t_put_cmd, t_del_cmd;

  int checks = 0;
  int errors = 0;

  ctrl_main_fsm dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_op(req_op),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_status(resp_status),
    .i_hit(hit),
    .o_get_enter(get_enter), .o_get_en(get_en), .i_get_cmd(get_cmd),
    .o_put_enter(put_enter), .o_put_en(put_en), .i_put_cmd(put_cmd),
    .o_del_enter(del_enter), .o_del_en(del_en), .i_del_cmd(del_cmd),
    .o_busy(busy)
  );

  ctrl_main_fsm #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(t_req_valid), .o_req_ready(t_req_ready), .i_req_op(t_req_op),
    .o_resp_valid(t_resp_valid), .i_resp_ready(t_resp_ready), .o_resp_status(t_resp_status),
    .i_hit(t_hit),
    .o_get_enter(t_get_enter), .o_get_en(t_get_en), .i_get_cmd(t_get_cmd),
    .o_put_enter(t_put_enter), .o_put_en(t_put_en), .i_put_cmd(t_put_cmd),
    .o_del_enter(t_del_enter), .o_del_en(t_del_en), .i_del_cmd(t_del_cmd),
    .o_busy(t_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++;
    if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL reset_valid_busy got %b exp 00", {resp_valid, busy}); end
    checks++;
    if ({get_enter, get_en, put_enter, put_en, del_enter, del_en} !== 6'b0) begin
      errors++; $display("FAIL reset_enter_en got %b exp 000000", {get_enter, get_en, put_enter, put_en, del_enter, del_en});
    end
    checks++;
    if ({t_req_ready, t_resp_valid, t_busy, t_del_en} !== 4'b1000) begin
      errors++; $display("FAIL reset_to_inst got %b exp 1000", {t_req_ready, t_resp_valid, t_busy, t_del_en});
    end
  endtask

  // GET with done in the first en cycle; resp at T+3
  task automatic test_get(input logic h, input logic [1:0] exp_st);
    hit = h; req_op = 2'd1; req_valid = 1'b1;
    tick();                                   // accepted at this edge (cycle T)
    req_valid = 1'b0;
    checks++;
    if ({get_enter, get_en, resp_valid} !== 3'b100) begin
      errors++; $display("FAIL get_dispatch got %b exp 100", {get_enter, get_en, resp_valid});
    end
    get_cmd.done = 1'b1;
    tick();
    checks++;
    if ({get_enter, get_en, resp_valid} !== 3'b010) begin
      errors++; $display("FAIL get_run got %b exp 010", {get_enter, get_en, resp_valid});
    end
    tick();
    get_cmd.done = 1'b0;
    checks++;
    if ({resp_valid, resp_status} !== {1'b1, exp_st}) begin
      errors++; $display("FAIL get_resp got %b exp %b", {resp_valid, resp_status}, {1'b1, exp_st});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, busy, resp_valid} !== 3'b100) begin
      errors++; $display("FAIL get_back_idle got %b exp 100", {req_ready, busy, resp_valid});
    end
  endtask

  // PUT done after 5 en cycles; response back-pressured for 3 cycles
  task automatic test_put_backpressure();
    int n_en = 0;
    logic bad = 1'b0;
    req_op = 2'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({put_enter, put_en} !== 2'b10) begin errors++; $display("FAIL put_dispatch got %b exp 10", {put_enter, put_en}); end
    tick();
    for (int i = 0; i < 5; i++) begin
      if (put_en === 1'b1) n_en++;
      if (req_ready !== 1'b0 || del_enter !== 1'b0 || del_en !== 1'b0) bad = 1'b1;
      put_cmd.done = (i == 4);
      if (i == 1) begin req_valid = 1'b1; req_op = 2'd3; end   // must be ignored
      tick();
    end
    put_cmd.done = 1'b0;
    req_valid = 1'b0;
    checks++;
    if (n_en !== 5) begin errors++; $display("FAIL put_en_cycles got %0d exp 5", n_en); end
    checks++;
    if ({put_en, resp_valid, resp_status} !== {2'b01, 2'd0}) begin
      errors++; $display("FAIL put_resp got %b exp 0100", {put_en, resp_valid, resp_status});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_status !== 2'd0 || req_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL put_hold got %b exp 0", bad); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin errors++; $display("FAIL put_back_idle got %b exp 10", {req_ready, resp_valid}); end
  endtask

  // DEL on the 4-cycle instance; done on cycle done_at (0 = never)
  task automatic test_timeout(input int done_at, input logic [1:0] exp_st);
    int n = 0;
    t_req_op = 2'd3; t_req_valid = 1'b1;
    tick();
    t_req_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (t_del_en !== 1'b1) break;
      n++;
      t_del_cmd.done = (n == done_at);
      tick();
    end
    t_del_cmd.done = 1'b0;
    checks++;
    if (n !== 4) begin errors++; $display("FAIL to_en_cycles done_at=%0d got %0d exp 4", done_at, n); end
    checks++;
    if ({t_resp_valid, t_resp_status} !== {1'b1, exp_st}) begin
      errors++; $display("FAIL to_status done_at=%0d got %b exp %b", done_at, {t_resp_valid, t_resp_status}, {1'b1, exp_st});
    end
    t_resp_ready = 1'b1;
    tick();
    t_resp_ready = 1'b0;
  endtask

  task automatic test_nop();
    req_op = 2'd0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if ({resp_valid, resp_status, busy} !== {1'b1, 2'd3, 1'b1}) begin
      errors++; $display("FAIL nop_resp got %b exp 1111", {resp_valid, resp_status, busy});
    end
    checks++;
    if ({get_enter, put_enter, del_enter} !== 3'b000) begin
      errors++; $display("FAIL nop_enter got %b exp 000", {get_enter, put_enter, del_enter});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL nop_back_idle got %b exp 1", req_ready); end
  endtask

  // GET with put_cmd.done stuck high; get done on 3rd en cycle
  task automatic test_crosstalk();
    int n = 0;
    logic bad = 1'b0;
    hit = 1'b1; req_op = 2'd1; req_valid = 1'b1;
    put_cmd.done = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (get_en !== 1'b1) break;
      if (put_enter !== 1'b0 || put_en !== 1'b0) bad = 1'b1;
      n++;
      get_cmd.done = (n == 3);
      tick();
    end
    get_cmd.done = 1'b0;
    put_cmd.done = 1'b0;
    checks++;
    if ({n, bad} !== {32'd3, 1'b0}) begin errors++; $display("FAIL xtalk_cycles got %0d/%b exp 3/0", n, bad); end
    checks++;
    if ({resp_valid, resp_status} !== 3'b100) begin errors++; $display("FAIL xtalk_status got %b exp 100", {resp_valid, resp_status}); end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    hit = 1'b1; req_op = 2'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if (get_en !== 1'b1) begin errors++; $display("FAIL rst_pre_run got %b exp 1", get_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({get_en, req_ready, busy, resp_valid} !== 4'b0100) begin
      errors++; $display("FAIL rst_async got %b exp 0100", {get_en, req_ready, busy, resp_valid});
    end
    tick();
    rst_n = 1'b1;
    tick();
    test_get(1'b1, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 2'd0; resp_ready = 1'b0; hit = 1'b0;
    get_cmd = '0; put_cmd = '0; del_cmd = '0;
    t_req_valid = 1'b0; t_req_op = 2'd0; t_resp_ready = 1'b0; t_hit = 1'b0;
    t_get_cmd = '0; t_put_cmd = '0; t_del_cmd = '0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_get(1'b1, 2'd0);
    test_get(1'b0, 2'd1);
    test_put_backpressure();
    test_timeout(0, 2'd2);
    test_timeout(4, 2'd0);
    test_nop();
    test_crosstalk();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ctrl_main_fsm

`default_nettype wire
